fifo_client: RTL and testbench

Client-side controller for the FIFO interface: drives the write and read enables that the FIFO modport consumes and turns the FIFO's full/empty/error outputs into two valid/ready streams. The write path forwards a producer stream into the FIFO. The read path prefetches from the FIFO into a 2-entry output buffer so the consumer sees registered, zero-bubble data. It sits between the FIFO instance and the datapath logic that produces and consumes words.

---
 rtl/fifo_client.sv | 101 ++++++++++
 tb/tb_fifo_client.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_client.sv
// Client-side controller for a FIFO: combinational write forwarding plus a
// 2-entry prefetch buffer on the read side. Optional error counters: FIFO_CLIENT_ERR_CNT_EN.
module fifo_client #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  output logic                     fifo_wr_en,
  output logic [DATA_WIDTH-1:0]    fifo_wr_data,
  output logic                     fifo_rd_en,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  input  logic                     fifo_wr_err,
  input  logic                     fifo_rd_err,
  input  logic [DATA_WIDTH-1:0]    fifo_rd_data,
  output logic                     proto_err,
  output logic [ERR_CNT_WIDTH-1:0] wr_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] rd_err_cnt
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  head_q;
  logic [CNT_W-1:0]      count_q;
  logic                  inflight_q;
  logic                  proto_err_q;
  logic                  pop;
  logic                  capture;
  logic                  tail;
  logic [OCC_W-1:0]      occ;

  // Write path: pure forwarding, no storage
  assign in_ready     = !fifo_full;
  assign fifo_wr_en   = in_valid & !fifo_full;
  assign fifo_wr_data = in_data;

  assign out_valid = (count_q != CNT_W'(0));
  assign out_data  = buf_q[head_q];
  assign pop       = out_valid & out_ready;
  assign capture   = inflight_q & !fifo_rd_err;
  assign tail      = head_q ^ count_q[0];
  assign occ       = OCC_W'(count_q) + OCC_W'(inflight_q);

  // Issue a read only if the word will have a slot when it lands; held off in reset
  assign fifo_rd_en = nRST & !fifo_empty & ((occ < OCC_W'(2)) | pop);

  always_ff @(posedge CLK) begin
    if (capture) buf_q[tail] <= fifo_rd_data;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q      <= 1'b0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      inflight_q  <= fifo_rd_en;
      count_q     <= CNT_W'(count_q + CNT_W'(capture) - CNT_W'(pop));
      if (pop) head_q <= ~head_q;
      if (fifo_wr_err || fifo_rd_err) proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;

`ifdef FIFO_CLIENT_ERR_CNT_EN
  logic                     rd_drop;
  logic [ERR_CNT_WIDTH-1:0] wr_cnt_q;
  logic [ERR_CNT_WIDTH-1:0] rd_cnt_q;

  assign rd_drop = inflight_q & fifo_rd_err;

  // Saturating error counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (fifo_wr_err && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + ERR_CNT_WIDTH'(1);
      if (rd_drop && (rd_cnt_q != '1))     rd_cnt_q <= rd_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  assign wr_err_cnt = wr_cnt_q;
  assign rd_err_cnt = rd_cnt_q;
`else
  assign wr_err_cnt = '0;
  assign rd_err_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_client.sv
// Directed bench for fifo_client: behavioural FIFO read model plus a queue
// scoreboard of the words the consumer must see, in order.
module tb_fifo_client;

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 8;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_rd_en;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_wr_err;
  logic          fifo_rd_err;
  logic [DW-1:0] fifo_rd_data;
  logic          proto_err;
  logic [EW-1:0] wr_err_cnt;
  logic [EW-1:0] rd_err_cnt;

  fifo_client #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_wr_err(fifo_wr_err),
    .fifo_rd_err(fifo_rd_err), .fifo_rd_data(fifo_rd_data), .proto_err(proto_err),
    .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt)
  );

  always #5 CLK = ~CLK;

  // Read side of the FIFO: data appears the cycle after fifo_rd_en; not reset by nRST
  logic [DW-1:0] fmem [64];
  int            rp = 0;
  int            wp = 0;
  assign fifo_empty = (rp == wp);
  always @(posedge CLK) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rp];
      rp <= rp + 1;
    end
  end

  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;
  int rd_pulses = 0;
  int first_rd = -1;
  int first_beat = -1;
  int last_beat = -1;
  bit last_rd = 1'b0;
`ifdef FIFO_CLIENT_ERR_CNT_EN
  localparam logic [EW-1:0] EXP_RD_CNT = EW'(1);
  localparam logic [EW-1:0] EXP_WR_CNT = EW'(3);
`else
  localparam logic [EW-1:0] EXP_RD_CNT = EW'(0);
  localparam logic [EW-1:0] EXP_WR_CNT = EW'(0);
`endif

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge (rd_en, output beat vs scoreboard), return at posedge+1
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge CLK);
    last_rd = fifo_rd_en;
    if (fifo_rd_en) begin
      rd_pulses++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", out_data, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", out_data, e);
      end
      beats++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic prefill(input logic [DW-1:0] base, input int n, input bit expect_it);
    for (int i = 0; i < n; i++) begin
      fmem[wp + i] = base + DW'(i);
      if (expect_it) exp_q.push_back(base + DW'(i));
    end
    wp = wp + n;
  endtask

  task automatic clear_stats();
    rd_pulses = 0; first_rd = -1; beats = 0; first_beat = -1; last_beat = -1;
  endtask

  initial begin
    bit seen;
    nRST = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    fifo_full = 1'b0; fifo_wr_err = 1'b0; fifo_rd_err = 1'b0;
    #1;
    chk("rst_out_valid", DW'(out_valid), 0);
    chk("rst_rd_en", DW'(fifo_rd_en), 0);
    chk("rst_proto_err", DW'(proto_err), 0);
    chk("rst_wr_cnt", DW'(wr_err_cnt), 0);
    chk("rst_rd_cnt", DW'(rd_err_cnt), 0);
    tick(); tick();
    nRST = 1'b1;

    // Idle with empty FIFO
    clear_stats();
    for (int i = 0; i < 10; i++) tick();
    chk("idle_out_valid", DW'(out_valid), 0);
    chk("idle_rd_pulses", DW'(rd_pulses), 0);
    chk("idle_proto_err", DW'(proto_err), 0);

    // Write path forwarding and full backpressure
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      #1;
      chk("wr_en", DW'(fifo_wr_en), 1);
      chk("wr_data", fifo_wr_data, DW'(i));
      chk("wr_in_ready", DW'(in_ready), 1);
      tick();
    end
    fifo_full = 1'b1;
    #1;
    chk("full_in_ready", DW'(in_ready), 0);
    chk("full_wr_en", DW'(fifo_wr_en), 0);
    fifo_full = 1'b0; in_valid = 1'b0;
    tick();

    // Streaming read with consumer always ready
    clear_stats();
    out_ready = 1'b1;
    prefill(32'hA0, 8, 1'b1);
    for (int i = 0; i < 14; i++) tick();
    chk("stream_latency", DW'(first_beat - first_rd), 2);
    chk("stream_beats", DW'(beats), 8);
    chk("stream_no_bubble", DW'(last_beat - first_beat), 7);
    chk("stream_sb_empty", DW'(exp_q.size()), 0);

    // Stalled consumer: only two reads issued, head holds first word
    clear_stats();
    out_ready = 1'b0;
    prefill(32'hA0, 8, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_rd_pulses", DW'(rd_pulses), 2);
    chk("stall_out_valid", DW'(out_valid), 1);
    chk("stall_head", out_data, 32'hA0);
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("stall_beats", DW'(beats), 8);
    chk("stall_sb_empty", DW'(exp_q.size()), 0);

    // Read error on the returning word: dropped, flagged, counted
    prefill(32'hDEAD, 1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = last_rd;
    end
    chk("rderr_rd_seen", DW'(seen), 1);
    fifo_rd_err = 1'b1;
    tick();
    fifo_rd_err = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rderr_out_valid", DW'(out_valid), 0);
    chk("rderr_proto_err", DW'(proto_err), 1);
    chk("rderr_cnt", DW'(rd_err_cnt), DW'(EXP_RD_CNT));
    for (int i = 0; i < 3; i++) begin
      fifo_wr_err = 1'b1; tick();
      fifo_wr_err = 1'b0; tick();
    end
    chk("wrerr_cnt", DW'(wr_err_cnt), DW'(EXP_WR_CNT));

    // Reset with a full buffer: buffered words dropped, FIFO contents kept
    clear_stats();
    out_ready = 1'b0;
    prefill(32'hB0, 8, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_out_valid", DW'(out_valid), 1);
    chk("mid_rd_pulses", DW'(rd_pulses), 2);
    nRST = 1'b0;
    #1;
    chk("mid_rst_out_valid", DW'(out_valid), 0);
    chk("mid_rst_rd_en", DW'(fifo_rd_en), 0);
    chk("mid_rst_proto_err", DW'(proto_err), 0);
    tick(); tick();
    nRST = 1'b1;
    for (int i = 2; i < 8; i++) exp_q.push_back(32'hB0 + DW'(i));
    clear_stats();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("resume_beats", DW'(beats), 6);
    chk("resume_sb_empty", DW'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
